angle_to_steps_mc: RTL

//  Multi-channel successor to the theta->steps converter: turns N_CH signed fixed-point joint angles (rad)

---
 rtl/scara_steps_pkg.sv | 27 ++
 rtl/angle_to_steps_mc_if.sv | 29 ++
 rtl/step_round_sat.sv | 50 +++++
 rtl/angle_to_steps_mc.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/scara_steps_pkg.sv
// Shared types, default scaling constants and rounding helper for the angle-to-steps converter.
package scara_steps_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RND  = 2'd2,
        DONE = 2'd3
    } state_t;

    // 31.831 steps/rad in Q.10
    localparam int unsigned K_STEPS_DEF = 32595;
    localparam int unsigned K_FRAC_DEF  = 10;

    // Arithmetic right shift by s with round-half-away-from-zero (s >= 1).
    // A negative operand gets a bias one smaller so that exact halves move away from zero.
    function automatic logic signed [63:0] round_shift_haz(input logic signed [63:0] prod,
                                                           input int unsigned       s);
        logic signed [63:0] bias;
        bias = 64'sd1 <<< (s - 1);
        if (prod[63]) begin
            bias = bias - 64'sd1;
        end
        return (prod + bias) >>> s;
    endfunction

endpackage

// File: rtl/angle_to_steps_mc_if.sv
// Request/response bundle between the IK block (master) and the converter (slave).
interface angle_to_steps_mc_if #(
    parameter int unsigned N_CH   = 2,
    parameter int unsigned TH_W   = 13,
    parameter int unsigned STEP_W = 9,
    parameter int unsigned POS_W  = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [N_CH*TH_W-1:0]     th;
    logic                     rel_mode;
    logic                     clear_pos;
    logic                     out_valid;
    logic                     out_ready;
    logic [N_CH*STEP_W-1:0]   steps;
    logic [N_CH-1:0]          dir;
    logic [N_CH-1:0]          sat;
    logic [N_CH*POS_W-1:0]    pos;

    modport master (
        output in_valid, th, rel_mode, clear_pos, out_ready,
        input  in_ready, out_valid, steps, dir, sat, pos
    );

    modport slave (
        input  in_valid, th, rel_mode, clear_pos, out_ready,
        output in_ready, out_valid, steps, dir, sat, pos
    );
endinterface

// File: rtl/step_round_sat.sv
// Combinational round / offset / clamp / abs / direction for one channel.
module step_round_sat
    import scara_steps_pkg::*;
#(
    parameter int unsigned PROD_W = 29,
    parameter int unsigned POS_W  = 16,
    parameter int unsigned STEP_W = 9,
    parameter int unsigned S      = 20
) (
    input  logic signed [PROD_W-1:0] prod,
    input  logic signed [POS_W-1:0]  pos,
    input  logic                     rel_mode,
    output logic [STEP_W-1:0]        steps_c,
    output logic                     dir_c,
    output logic                     sat_c,
    output logic signed [POS_W-1:0]  pos_nxt_c
);
    localparam int unsigned DW = POS_W + 1;
    localparam int unsigned SW = POS_W + 2;
    localparam logic [DW-1:0]        MAG_MAX = DW'((64'd1 << STEP_W) - 64'd1);
    localparam logic signed [SW-1:0] POS_MAX = SW'((64'sd1 <<< (POS_W - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] POS_MIN = ~POS_MAX;

    logic signed [DW-1:0] tgt;
    logic signed [DW-1:0] delta;
    logic signed [DW-1:0] delta_cl;
    logic [DW-1:0]        mag;
    logic [DW-1:0]        mag_cl;
    logic signed [SW-1:0] sum;

    // Target in steps, delta against the current position, clamp and saturating position update.
    always_comb begin
        tgt       = DW'(round_shift_haz(64'(prod), S));
        delta     = rel_mode ? (tgt - DW'(pos)) : tgt;
        dir_c     = ~delta[DW-1];
        mag       = dir_c ? delta : -delta;
        sat_c     = (mag > MAG_MAX);
        mag_cl    = sat_c ? MAG_MAX : mag;
        steps_c   = STEP_W'(mag_cl);
        delta_cl  = dir_c ? $signed(mag_cl) : -$signed(mag_cl);
        sum       = SW'(pos) + SW'(delta_cl);
        pos_nxt_c = POS_W'(sum);
        if (sum > POS_MAX) begin
            pos_nxt_c = POS_W'(POS_MAX);
        end else if (sum < POS_MIN) begin
            pos_nxt_c = POS_W'(POS_MIN);
        end
    end

endmodule

// File: rtl/angle_to_steps_mc.sv
// Multi-channel joint angle to stepper command converter with one shared multiplier.
module angle_to_steps_mc
    import scara_steps_pkg::*;
#(
    parameter int unsigned N_CH    = 2,
    parameter int unsigned TH_W    = 13,
    parameter int unsigned TH_FRAC = 10,
    parameter int unsigned K_W     = 16,
    parameter int unsigned K_FRAC  = K_FRAC_DEF,
    parameter int unsigned K_STEPS = K_STEPS_DEF,
    parameter int unsigned STEP_W  = 9,
    parameter int unsigned POS_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    angle_to_steps_mc_if.slave bus
);
    localparam int unsigned PROD_W = TH_W + K_W;
    localparam int unsigned S      = TH_FRAC + K_FRAC;
    localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_t                    state_q, state_nxt;
    logic [CH_W-1:0]           ch_q, ch_nxt;
    logic [N_CH*TH_W-1:0]      th_q;
    logic                      rel_q;
    logic signed [PROD_W-1:0]  prod_q;
    logic                      idle_q;
    logic                      out_valid_q, out_valid_nxt;
    logic [N_CH*STEP_W-1:0]    steps_q;
    logic [N_CH-1:0]           dir_q;
    logic [N_CH-1:0]           sat_q;
    logic [N_CH*POS_W-1:0]     pos_q;

    logic                      ld_in, ld_prod, ld_res, clr_pos;
    logic signed [TH_W-1:0]    th_sel;
    logic signed [POS_W-1:0]   pos_sel;
    logic signed [PROD_W-1:0]  prod_c;
    logic [STEP_W-1:0]         steps_c;
    logic                      dir_c, sat_c;
    logic signed [POS_W-1:0]   pos_nxt_c;

    // Channel operand select and the shared multiplier.
    always_comb begin
        th_sel  = th_q[32'(ch_q) * TH_W +: TH_W];
        pos_sel = pos_q[32'(ch_q) * POS_W +: POS_W];
        prod_c  = PROD_W'(th_sel) * $signed(PROD_W'(K_STEPS));
    end

    step_round_sat #(
        .PROD_W (PROD_W),
        .POS_W  (POS_W),
        .STEP_W (STEP_W),
        .S      (S)
    ) u_round (
        .prod      (prod_q),
        .pos       (pos_sel),
        .rel_mode  (rel_q),
        .steps_c   (steps_c),
        .dir_c     (dir_c),
        .sat_c     (sat_c),
        .pos_nxt_c (pos_nxt_c)
    );

    // State, channel counter and handshake flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            idle_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            ch_q        <= ch_nxt;
            idle_q      <= (state_nxt == IDLE);
            out_valid_q <= out_valid_nxt;
        end
    end

    // Next-state and datapath strobes; out_valid rises one cycle into DONE.
    always_comb begin
        state_nxt     = state_q;
        ch_nxt        = ch_q;
        out_valid_nxt = 1'b0;
        ld_in         = 1'b0;
        ld_prod       = 1'b0;
        ld_res        = 1'b0;
        clr_pos       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.clear_pos) begin
                    clr_pos = 1'b1;
                end else if (bus.in_valid && idle_q) begin
                    ld_in     = 1'b1;
                    ch_nxt    = '0;
                    state_nxt = MUL;
                end
            end
            MUL: begin
                ld_prod   = 1'b1;
                state_nxt = RND;
            end
            RND: begin
                ld_res = 1'b1;
                if (ch_q == CH_W'(N_CH - 1)) begin
                    state_nxt = DONE;
                end else begin
                    ch_nxt    = ch_q + CH_W'(1);
                    state_nxt = MUL;
                end
            end
            DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    state_nxt = IDLE;
                end else begin
                    out_valid_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Input capture, product register and per-channel result/position registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            th_q    <= '0;
            rel_q   <= 1'b0;
            prod_q  <= '0;
            steps_q <= '0;
            dir_q   <= '0;
            sat_q   <= '0;
            pos_q   <= '0;
        end else begin
            if (ld_in) begin
                th_q  <= bus.th;
                rel_q <= bus.rel_mode;
            end
            if (ld_prod) begin
                prod_q <= prod_c;
            end
            if (clr_pos) begin
                pos_q <= '0;
            end else if (ld_res) begin
                steps_q[32'(ch_q) * STEP_W +: STEP_W] <= steps_c;
                dir_q[ch_q]                           <= dir_c;
                sat_q[ch_q]                           <= sat_c;
                pos_q[32'(ch_q) * POS_W +: POS_W]     <= pos_nxt_c;
            end
        end
    end

    assign bus.in_ready  = idle_q & ~bus.clear_pos;
    assign bus.out_valid = out_valid_q;
    assign bus.steps     = steps_q;
    assign bus.dir       = dir_q;
    assign bus.sat       = sat_q;
    assign bus.pos       = pos_q;

endmodule
